branch_predict_unit: RTL

//  Execute-stage consumer of the branch comparator's io_BrEq/io_BrLt.
//  - Decodes funct3 into a taken/not-taken outcome and drives io_BrUn back to the comparator.
//  - Resolves against the decode-stage prediction; raises mispredict plus redirect PC.
//  - Trains a direct-mapped table (BHT) of 2-bit saturating counters that supplies decode-stage predictions.

---
 rtl/branch_predict_unit.sv | 71 +++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: branch resolve, mispredict/redirect and 2-bit BHT predictor (optional BRANCH_STATS_EN stats)
module branch_predict_unit #(
    parameter int BHT_ENTRIES = 32,
    parameter int IDX_W = $clog2(BHT_ENTRIES)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_stall,
    input  logic        io_d_is_branch,
    input  logic [31:0] io_d_pc,
    output logic        io_d_pred_taken,
    input  logic        io_x_valid,
    input  logic        io_x_is_branch,
    input  logic [2:0]  io_x_funct3,
    input  logic [31:0] io_x_pc,
    input  logic [31:0] io_x_target,
    input  logic        io_x_pred_taken,
    input  logic        io_BrEq,
    input  logic        io_BrLt,
    output logic        io_BrUn,
    output logic        io_x_taken,
    output logic        io_x_mispredict,
    output logic [31:0] io_x_redirect_pc,
    output logic [31:0] io_stat_branches,
    output logic [31:0] io_stat_mispred
);
    logic [1:0] ctr [BHT_ENTRIES];
    logic [IDX_W-1:0] x_idx, d_idx;
    logic [1:0] x_nxt;
    logic legal, cond, res;
    logic unused_pc;
    assign x_idx = io_x_pc[IDX_W+1:2];
    assign d_idx = io_d_pc[IDX_W+1:2];
    assign unused_pc = ^{io_d_pc[31:IDX_W+2], io_d_pc[1:0]};
    assign io_BrUn = io_x_funct3[1];
    // resolve: funct3[2] picks lt vs eq, funct3[0] inverts; 010/011 are illegal
    always_comb begin
        legal = ~(~io_x_funct3[2] & io_x_funct3[1]);
        cond = (io_x_funct3[2] ? io_BrLt : io_BrEq) ^ io_x_funct3[0];
        res = io_x_valid & io_x_is_branch & ~io_stall & legal & ~reset;
        io_x_taken = res & cond;
        io_x_mispredict = res & (cond != io_x_pred_taken);
        io_x_redirect_pc = io_x_mispredict ? (cond ? io_x_target : io_x_pc + 32'd4) : 32'd0;
        x_nxt = cond ? (ctr[x_idx] == 2'b11 ? 2'b11 : ctr[x_idx] + 2'd1)
                     : (ctr[x_idx] == 2'b00 ? 2'b00 : ctr[x_idx] - 2'd1);
        io_d_pred_taken = io_d_is_branch & ~reset &
                          ((res && d_idx == x_idx) ? x_nxt[1] : ctr[d_idx][1]);
    end
    // counter table: reset to weakly not-taken, train on each resolved branch
    always_ff @(posedge clock) begin
        if (reset)
            for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= 2'b01;
        else if (res)
            ctr[x_idx] <= x_nxt;
    end
`ifdef BRANCH_STATS_EN
    // wrapping resolved-branch and mispredict counters
    always_ff @(posedge clock) begin
        if (reset) begin
            io_stat_branches <= 32'd0;
            io_stat_mispred <= 32'd0;
        end else begin
            if (res) io_stat_branches <= io_stat_branches + 32'd1;
            if (io_x_mispredict) io_stat_mispred <= io_stat_mispred + 32'd1;
        end
    end
`else
    assign io_stat_branches = 32'd0;
    assign io_stat_mispred = 32'd0;
`endif
endmodule
